// File: rtl/wbp2axilrd_pkg.sv
// Shared types for the WB-to-AXI-lite read bridge.
// AXI response codes and bridge state encoding.
package wbp2axilrd_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/wbp2axilrd.sv
// Pipelined Wishbone slave to AXI-lite read master bridge.
// Writes are refused with a bus error; reads return in order.
module wbp2axilrd
    import wbp2axilrd_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int LGFIFO           = 3,
    localparam int AW = C_AXI_ADDR_WIDTH - $clog2(C_AXI_DATA_WIDTH / 8)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wb_cyc,
    input  logic                          i_wb_stb,
    input  logic                          i_wb_we,
    input  logic [AW-1:0]                 i_wb_addr,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] i_wb_sel,
    output logic                          o_wb_stall,
    output logic                          o_wb_ack,
    output logic                          o_wb_err,
    output logic [C_AXI_DATA_WIDTH-1:0]   o_wb_data,
    output logic                          o_axi_arvalid,
    input  logic                          i_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
    output logic [2:0]                    o_axi_arprot,
    input  logic                          i_axi_rvalid,
    output logic                          o_axi_rready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
    input  logic [1:0]                    i_axi_rresp
);

    localparam int DW  = C_AXI_DATA_WIDTH;
    localparam int LSB = $clog2(DW / 8);
    localparam int CW  = LGFIFO + 1;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] FLEN    = CNT_ONE << LGFIFO;

    state_t                      state_q, state_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        arvalid_q, arvalid_d;
    logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic [DW-1:0]               data_q, data_d;

    logic req;
    logic rd_accept;
    logic wr_accept;
    logic r_take;
    logic r_resp;
    logic r_bad;

    // Byte selects carry no meaning for whole-word reads.
    logic unused_sel;
    assign unused_sel = ^i_wb_sel;

    // Stall whenever a new request could not be tracked or ordered.
    always_comb begin
        o_wb_stall = i_reset
                  || (arvalid_q && !i_axi_arready)
                  || (count_q == FLEN)
                  || (state_q == FLUSH)
                  || (i_wb_we && (count_q != '0));
    end

    assign req       = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign rd_accept = req && !i_wb_we;
    assign wr_accept = req && i_wb_we;

    // A response with nothing outstanding is ignored entirely.
    assign r_take = i_axi_rvalid && (count_q != '0);
    assign r_resp = r_take && (state_q == BUSY) && i_wb_cyc;
    assign r_bad  = (i_axi_rresp == AXI_RESP_SLVERR)
                 || (i_axi_rresp == AXI_RESP_DECERR);

    assign o_axi_rready  = !i_reset;
    assign o_axi_arprot  = 3'b000;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_araddr  = araddr_q;
    assign o_wb_ack      = ack_q;
    assign o_wb_err      = err_q;
    assign o_wb_data     = data_q;

    // Outstanding-read counter: accept adds, response retires.
    always_comb begin
        count_d = count_q;
        if (rd_accept && !r_take) begin
            count_d = count_q + CNT_ONE;
        end else if (!rd_accept && r_take) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Next state: flush abandons responses after cyc drop or error.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_d == '0) begin
                    state_d = IDLE;
                end else if (!i_wb_cyc || (r_resp && r_bad)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if ((count_d == '0) && !arvalid_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: AR channel hold, WB response strobes and read data.
    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        data_d    = data_q;
        if (arvalid_q && i_axi_arready) begin
            arvalid_d = 1'b0;
        end
        if (rd_accept) begin
            arvalid_d = 1'b1;
            araddr_d  = C_AXI_ADDR_WIDTH'(i_wb_addr) << LSB;
        end
        if (r_resp) begin
            data_d = i_axi_rdata;
            ack_d  = !r_bad;
            err_d  = r_bad;
        end
        if (wr_accept) begin
            err_d = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            count_q   <= count_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_wbp2axilrd.sv
// Self-checking bench for the WB-to-AXI-lite read bridge.
// Scoreboard of expected WB responses plus directed scenarios.
module tb_wbp2axilrd;
    import wbp2axilrd_pkg::*;

    localparam logic [25:0] ERR_ADDR = 26'h300;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [25:0] addr;
    logic [3:0]  sel;
    logic        stall, ack, err;
    logic [31:0] wdata_o;
    logic        arvalid, arready;
    logic [27:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [27:0] expar[$];
    logic [27:0] arq[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_resp   = 0;
    int base;

    always #5 clk = ~clk;

    wbp2axilrd dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .i_wb_sel     (sel),
        .o_wb_stall   (stall),
        .o_wb_ack     (ack),
        .o_wb_err     (err),
        .o_wb_data    (wdata_o),
        .o_axi_arvalid(arvalid),
        .i_axi_arready(arready),
        .o_axi_araddr (araddr),
        .o_axi_arprot (arprot),
        .i_axi_rvalid (rvalid),
        .o_axi_rready (rready),
        .i_axi_rdata  (rdata),
        .i_axi_rresp  (rresp)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [25:0] a);
        if (a == 26'h10) return 32'hDEADBEEF;
        return {6'h2A, a};
    endfunction

    // Monitor: responses, AR handshakes, WB accepts.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack || err) begin
                check("ack_err_excl", 64'(ack && err), 0);
                if (sb.size() == 0) begin
                    check("unexpected_resp", {ack, err}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_resp++;
                    check("resp_kind", err, e.err);
                    if (ack) check("resp_data", wdata_o, e.data);
                end
            end
            if (arvalid && arready) begin
                if (expar.size() == 0) begin
                    check("unexpected_ar", 1, 0);
                end else begin
                    check("ar_addr", araddr, expar.pop_front());
                end
                arq.push_back(araddr);
            end
            if (cyc && stb && !stall) begin
                exp_t e;
                if (we) begin
                    e.err  = 1'b1;
                    e.data = '0;
                end else begin
                    e.err  = (addr == ERR_ADDR);
                    e.data = rd_data(addr);
                    expar.push_back({addr, 2'b00});
                end
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_burst(input int n, input logic [1:0] r0);
        for (int i = 0; i < n; i++) begin
            logic [27:0] a;
            if (arq.size() == 0) begin
                check("r_without_ar", 1, 0);
                break;
            end
            a      = arq.pop_front();
            rvalid = 1'b1;
            rdata  = rd_data(a[27:2]);
            rresp  = (i == 0) ? r0 : AXI_RESP_OKAY;
            step();
        end
        rvalid = 1'b0;
    endtask

    task automatic issue_reads(input logic [25:0] a0, input int n);
        cyc = 1'b1;
        we  = 1'b0;
        for (int i = 0; i < n; i++) begin
            stb  = 1'b1;
            addr = a0 + 26'(i);
            step();
        end
        stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cyc = 0; stb = 0; we = 0; addr = '0; sel = 4'hF;
        arready = 1'b1; rvalid = 0; rdata = '0; rresp = '0;

        // Reset state.
        repeat (2) step();
        @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_data", wdata_o, 0);
        check("rst_araddr", araddr, 0);
        check("rst_stall", stall, 1);
        check("rst_rready", rready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("run_stall", stall, 0);
        check("run_rready", rready, 1);
        check("arprot", arprot, 0);

        // Single read with delayed response.
        step();
        issue_reads(26'h10, 1);
        @(negedge clk);
        check("t1_arvalid", arvalid, 1);
        check("t1_araddr", araddr, 28'h40);
        step();
        step();
        send_burst(1, AXI_RESP_OKAY);
        @(negedge clk);
        check("t1_ack", ack, 1);
        check("t1_data", wdata_o, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_ack_pulse", ack, 0);

        // Eight back-to-back reads fill the tracker.
        step();
        issue_reads(26'h100, 8);
        stb  = 1'b1;
        addr = 26'h108;
        @(negedge clk);
        check("t2_stall_full", stall, 1);
        check("t2_count", dut.count_q, 8);
        step();
        stb  = 1'b0;
        base = n_resp;
        send_burst(8, AXI_RESP_OKAY);
        repeat (2) @(negedge clk);
        check("t2_acks", n_resp - base, 8);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_idle", dut.state_q, IDLE);

        // Cyc drop after first ack flushes the rest.
        step();
        issue_reads(26'h200, 3);
        send_burst(1, AXI_RESP_OKAY);
        cyc = 1'b0;
        @(negedge clk);
        #1;
        sb.delete();
        step();
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = 26'h2FF;
        @(negedge clk);
        check("t3_flush_state", dut.state_q, FLUSH);
        check("t3_flush_stall", stall, 1);
        send_burst(2, AXI_RESP_OKAY);
        @(negedge clk);
        check("t3_stall_release", stall, 0);
        check("t3_data_hold", wdata_o, rd_data(26'h200));
        step();
        stb = 1'b0;
        step();
        send_burst(1, AXI_RESP_OKAY);
        repeat (2) @(negedge clk);
        check("t3_sb_empty", sb.size(), 0);

        // Slave error with two more outstanding.
        step();
        issue_reads(26'h300, 3);
        send_burst(1, AXI_RESP_SLVERR);
        @(negedge clk);
        check("t4_err", err, 1);
        #1;
        sb.delete();
        base = n_resp;
        stb  = 1'b1;
        addr = 26'h3FF;
        @(negedge clk);
        check("t4_flush_stall", stall, 1);
        check("t4_err_pulse", err, 0);
        stb = 1'b0;
        send_burst(2, AXI_RESP_OKAY);
        repeat (2) @(negedge clk);
        check("t4_no_acks", n_resp - base, 0);
        check("t4_idle", dut.state_q, IDLE);

        // Write waits for outstanding reads, then errors.
        step();
        issue_reads(26'h400, 2);
        we   = 1'b1;
        stb  = 1'b1;
        addr = 26'h7;
        @(negedge clk);
        check("t5_wr_stall2", stall, 1);
        send_burst(1, AXI_RESP_OKAY);
        @(negedge clk);
        check("t5_wr_stall1", stall, 1);
        send_burst(1, AXI_RESP_OKAY);
        @(negedge clk);
        check("t5_wr_go", stall, 0);
        step();
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        check("t5_wr_err", err, 1);
        check("t5_no_ar", arvalid, 0);
        @(negedge clk);
        check("t5_sb_empty", sb.size(), 0);

        // Reset while AR is held by the slave.
        step();
        arready = 1'b0;
        issue_reads(26'h500, 1);
        cyc = 1'b0;
        @(negedge clk);
        check("t6_arvalid", arvalid, 1);
        check("t6_araddr", araddr, 28'h1400);
        step();
        @(negedge clk);
        check("t6_ar_hold", arvalid, 1);
        check("t6_addr_hold", araddr, 28'h1400);
        check("t6_ar_stall", stall, 1);
        step();
        rst = 1'b1;
        sb.delete();
        expar.delete();
        arq.delete();
        @(negedge clk);
        check("t6_rst_stall", stall, 1);
        check("t6_rst_rready", rready, 0);
        step();
        @(negedge clk);
        check("t6_arvalid0", arvalid, 0);
        check("t6_araddr0", araddr, 0);
        check("t6_ack0", ack, 0);
        check("t6_err0", err, 0);
        check("t6_data0", wdata_o, 0);
        check("t6_idle", dut.state_q, IDLE);
        check("t6_count0", dut.count_q, 0);
        step();
        rst     = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        check("t6_stall_free", stall, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wbp2axilrd.md
WBP2AXILRD -- requirements
Module: wbp2axilrd

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 32, AXI and WB data width (DW).
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 28, AXI byte-address width.
REQ-003 SHALL have parameter LGFIFO, default 3, log2 of the maximum number of outstanding reads (FLEN = 2^LGFIFO).
REQ-004 SHALL have derived localparam AW = C_AXI_ADDR_WIDTH - log2(DW/8), the WB word-address width.
REQ-005 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  pipelined WB slave request.
REQ-008 i_wb_addr  in  AW  WB word address; i_wb_sel  in  DW/8  byte selects, ignored.
REQ-009 o_wb_stall  out  1  request not accepted this cycle.
REQ-010 o_wb_ack, o_wb_err  out  1 each  WB response strobes; o_wb_data  out  DW  read data.
REQ-011 o_axi_arvalid  out  1; i_axi_arready  in  1; o_axi_araddr  out  C_AXI_ADDR_WIDTH; o_axi_arprot  out  3.
REQ-012 i_axi_rvalid  in  1; o_axi_rready  out  1; i_axi_rdata  in  DW; i_axi_rresp  in  2.

Function
REQ-013 A request SHALL be accepted when i_wb_cyc && i_wb_stb && !o_wb_stall.
REQ-014 An accepted read SHALL, on the next cycle, set o_axi_arvalid=1 and o_axi_araddr={i_wb_addr, log2(DW/8) zero bits}.
REQ-015 o_axi_arvalid SHALL remain high with a stable address until i_axi_arready, even if i_wb_cyc drops.
REQ-016 o_axi_arprot SHALL be constant 3'b000.
REQ-017 o_wb_stall SHALL be combinational and high when any of these holds: i_reset; o_axi_arvalid && !i_axi_arready; outstanding count == FLEN; state FLUSH; i_wb_we && outstanding count != 0.
REQ-018 The outstanding counter (LGFIFO+1 bits) SHALL increment on read accept, decrement on i_axi_rvalid, and hold when both occur in the same cycle.
REQ-019 The counter SHALL never exceed FLEN or underflow; i_axi_rvalid at count 0 is a protocol violation and SHALL be ignored.
REQ-020 o_axi_rready SHALL be 1 whenever i_reset is low; responses are never backpressured.
REQ-021 On i_axi_rvalid in state BUSY with i_wb_cyc high, the block SHALL register o_wb_data <= i_axi_rdata and, one cycle later, pulse o_wb_ack if rresp[1]==0, else pulse o_wb_err.
REQ-022 An accepted write (i_wb_we=1) SHALL be accepted only at outstanding count 0, issue no AXI traffic, and pulse o_wb_err exactly one cycle later.
REQ-023 o_wb_ack and o_wb_err SHALL be single-cycle pulses, never both high, and responses SHALL return in request order.
REQ-024 State machine: IDLE (count 0) -> BUSY on read accept; BUSY -> IDLE when the count reaches 0; BUSY -> FLUSH on !i_wb_cyc or on an o_wb_err issued with count > 0 after the decrement; FLUSH -> IDLE when the count reaches 0 and o_axi_arvalid is low.
REQ-025 In FLUSH, R responses SHALL be consumed with no ack or err and o_wb_data unchanged.
REQ-026 If i_wb_cyc is low, o_wb_ack and o_wb_err SHALL be 0 on the following cycle.
REQ-027 Throughput SHALL be one read per clock when i_axi_arready=1 and the count is below FLEN; latency is WB accept to AR valid = 1 cycle, and R valid to WB ack = 1 cycle.

Reset
REQ-028 Under i_reset: o_axi_arvalid=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_axi_araddr=0, count=0, state=IDLE, o_wb_stall=1, o_axi_rready=0.
REQ-029 Reset mid-operation SHALL discard all outstanding state immediately; the AXI slave is reset by the same i_reset.

Structure
REQ-030 The shared package SHALL hold the AXI response codes (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) and the state enum {IDLE, BUSY, FLUSH}.
REQ-031 The block SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-032 Single read of address 0x0000010 with arready=1 and R returning 0xDEADBEEF/OKAY 3 cycles later -> araddr=0x0000040, ack pulse 1 cycle after rvalid, o_wb_data=0xDEADBEEF.
REQ-033 8 back-to-back reads with arready=1 and R withheld -> stall high on the 9th request; count=8; after 8 OKAY responses, 8 in-order acks and return to IDLE.
REQ-034 3 reads, then i_wb_cyc dropped after the first ack -> FLUSH; 2 remaining responses produce no ack; stall stays high until count=0.
REQ-035 Read returning rresp=2'b10 with 2 more outstanding -> one o_wb_err pulse, FLUSH, no further acks.
REQ-036 Write request with count=2 -> stalled until count=0, then accepted; o_wb_err 1 cycle later; no arvalid.
REQ-037 arready held low 5 cycles with cyc dropped and i_reset pulsed at cycle 3 -> all outputs reach reset values on the next edge and the block returns to IDLE.
